// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the buffer entry layout and the architectural fetch step.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pcplusfour;
    } ibuf_ent_t;

endpackage

// File: rtl/if_fetch_unit_inst_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO with push/pop/flush and a combinational head.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: pop on empty and push on full (without a pop) are ignored; flush wins.
module if_inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Purpose: fetch stage owning the PC, issuing in-order word fetches and buffering returns for IF/ID.
// Latency: >=1 cycle memory latency, then the response is at the head on the following cycle.
// Backpressure: stall holds the head; requests stop once outstanding + buffered reaches DEPTH.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_pcplusfour,
    output logic        IF_valid,
    output logic        nop
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] discard_q, discard_d;
    logic          nop_q, nop_d;

    logic [CW-1:0] buf_count;
    logic [CW-1:0] outstanding;
    logic [CW:0]   inflight_total;
    logic [31:0]   tag_head;
    ibuf_ent_t     buf_head;
    ibuf_ent_t     buf_push_dat;
    logic          accept, rsp_keep, buf_pop;

    always_comb begin
        inflight_total = {1'b0, outstanding} + {1'b0, buf_count};
        imem_req       = !Reset && !redirect_valid && (inflight_total < (CW+1)'(DEPTH));
        accept         = imem_req && imem_ready;
        rsp_keep       = imem_rvalid && (discard_q == '0) && !redirect_valid;
        buf_pop        = !stall && (buf_count != '0);
        buf_push_dat   = '{inst: imem_rdata, pcplusfour: tag_head + PC_STEP};

        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        nop_d      = redirect_valid;
        if (redirect_valid) begin
            // Every request still in flight after this edge belongs to the old path.
            fetch_pc_d = redirect_target;
            discard_d  = outstanding - CW'(imem_rvalid);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
            nop_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            nop_q      <= nop_d;
        end
    end

    // Issued-address queue; its occupancy is the outstanding-request count.
    if_inst_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk      (Clk),
        .rst      (Reset),
        .push     (accept),
        .push_dat (fetch_pc_q),
        .pop      (imem_rvalid),
        .flush    (1'b0),
        .count    (outstanding),
        .head_dat (tag_head)
    );

    if_inst_fifo #(
        .WIDTH ($bits(ibuf_ent_t)),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk      (Clk),
        .rst      (Reset),
        .push     (rsp_keep),
        .push_dat (buf_push_dat),
        .pop      (buf_pop),
        .flush    (redirect_valid),
        .count    (buf_count),
        .head_dat (buf_head)
    );

    assign imem_addr     = fetch_pc_q;
    assign IF_valid      = !Reset && (buf_count != '0);
    assign IF_inst       = IF_valid ? buf_head.inst : NOP_INST;
    assign IF_pcplusfour = IF_valid ? buf_head.pcplusfour : 32'h0000_0000;
    assign nop           = nop_q && !Reset;

    a_rvalid_has_request: assert property (@(posedge Clk) disable iff (Reset)
        imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: fixed vector table, directed sequences and randomized traffic
// checked against a queue-based model of the fetch stage and its memory.
module tb_if_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset, stall, redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_inst, IF_pcplusfour;
    logic        IF_valid, nop;

    always #5 Clk = ~Clk;

    if_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .IF_inst         (IF_inst),
        .IF_pcplusfour   (IF_pcplusfour),
        .IF_valid        (IF_valid),
        .nop             (nop)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    // ---------------- fixed vector table ----------------
    typedef struct {
        logic        rst, st, rd;
        logic [31:0] tgt;
        logic        rdy, rv;
        logic [31:0] rdat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_inst, e_pc4;
        logic        e_nop;
    } vec_t;

    vec_t tv[$];

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } infl_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } bent_t;

    infl_t       infl[$];
    bent_t       mbuf[$];
    logic [31:0] m_pc    = RST_PC;
    bit          m_nop   = 1'b0;
    int          lat_max = 1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'h2000_0000 + a;
    endfunction

    task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] tg, input bit rdy);
        bit          rsp, exp_req, has;
        logic [31:0] rdat;
        infl_t       e;
        bent_t       b;
        @(negedge Clk);
        Reset           = rst;
        stall           = st;
        redirect_valid  = rd;
        redirect_target = tg;
        imem_ready      = rdy;
        rsp  = !rst && (infl.size() > 0) && (infl[0].due <= cyc);
        rdat = rsp ? mem_data(infl[0].addr) : $urandom;
        imem_rvalid = rsp;
        imem_rdata  = rdat;
        exp_req = !rst && !rd && ((infl.size() + mbuf.size()) < DEPTH);
        has     = !rst && (mbuf.size() > 0);
        #1;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (!rst) chk("imem_addr", imem_addr, m_pc);
        chk("IF_valid", 32'(IF_valid), 32'(has));
        chk("IF_inst", IF_inst, has ? mbuf[0].inst : 32'h0);
        chk("IF_pcplusfour", IF_pcplusfour, has ? mbuf[0].pc4 : 32'h0);
        chk("nop", 32'(nop), 32'(!rst && m_nop));
        if (rst) begin
            infl.delete();
            mbuf.delete();
            m_pc  = RST_PC;
            m_nop = 1'b0;
        end else if (rd) begin
            if (rsp) e = infl.pop_front();
            foreach (infl[i]) infl[i].stale = 1'b1;
            mbuf.delete();
            m_pc  = tg;
            m_nop = 1'b1;
        end else begin
            if (!st && mbuf.size() > 0) b = mbuf.pop_front();
            if (rsp) begin
                e = infl.pop_front();
                if (!e.stale) mbuf.push_back('{rdat, e.addr + 32'd4});
            end
            if (exp_req && rdy) begin
                infl.push_back('{m_pc, 1'b0, cyc + int'($urandom_range(1, lat_max))});
                m_pc = m_pc + 32'd4;
            end
            m_nop = 1'b0;
        end
        @(posedge Clk);
        cyc++;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [31:0] tg;

        // rst st rd tgt  rdy rv rdata | req addr val inst pc4 nop
        tv.push_back(vec_t'{1,0,0,32'h0,  1,0,32'h0,        0,32'h0,  0,32'h0,        32'h0,  0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,0,32'h0,        1,32'h0,  0,32'h0,        32'h0,  0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,1,32'h20000000, 1,32'h4,  0,32'h0,        32'h0,  0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,1,32'h20000004, 0,32'h8,  1,32'h20000000, 32'h4,  0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,0,32'h0,        1,32'h8,  1,32'h20000004, 32'h8,  0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,0,32'h0,        1,32'hC,  0,32'h0,        32'h0,  0});
        tv.push_back(vec_t'{0,0,1,32'h100,1,0,32'h0,        0,32'h10, 0,32'h0,        32'h0,  0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,1,32'h20000008, 0,32'h100,0,32'h0,        32'h0,  1});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,1,32'h2000000C, 1,32'h100,0,32'h0,        32'h0,  0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,1,32'h20000100, 1,32'h104,0,32'h0,        32'h0,  0});
        tv.push_back(vec_t'{0,1,0,32'h0,  1,1,32'h20000104, 0,32'h108,1,32'h20000100, 32'h104,0});
        tv.push_back(vec_t'{0,1,0,32'h0,  1,0,32'h0,        0,32'h108,1,32'h20000100, 32'h104,0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,0,32'h0,        0,32'h108,1,32'h20000100, 32'h104,0});
        tv.push_back(vec_t'{0,1,0,32'h0,  1,0,32'h0,        1,32'h108,1,32'h20000104, 32'h108,0});
        tv.push_back(vec_t'{0,1,1,32'h100,1,1,32'h20000108, 0,32'h10C,1,32'h20000104, 32'h108,0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,0,32'h0,        1,32'h100,0,32'h0,        32'h0,  1});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,1,32'h20000100, 1,32'h104,0,32'h0,        32'h0,  0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,0,32'h0,        0,32'h108,1,32'h20000100, 32'h104,0});
        tv.push_back(vec_t'{0,0,0,32'h0,  1,1,32'h20000104, 1,32'h108,0,32'h0,        32'h0,  0});

        Reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(posedge Clk);
        cyc++;

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge Clk);
            Reset           = tv[i].rst;
            stall           = tv[i].st;
            redirect_valid  = tv[i].rd;
            redirect_target = tv[i].tgt;
            imem_ready      = tv[i].rdy;
            imem_rvalid     = tv[i].rv;
            imem_rdata      = tv[i].rdat;
            #1;
            chk($sformatf("tv%0d_req", i),   32'(imem_req), 32'(tv[i].e_req));
            chk($sformatf("tv%0d_addr", i),  imem_addr,     tv[i].e_addr);
            chk($sformatf("tv%0d_valid", i), 32'(IF_valid), 32'(tv[i].e_val));
            chk($sformatf("tv%0d_inst", i),  IF_inst,       tv[i].e_inst);
            chk($sformatf("tv%0d_pc4", i),   IF_pcplusfour, tv[i].e_pc4);
            chk($sformatf("tv%0d_nop", i),   32'(nop),      32'(tv[i].e_nop));
            @(posedge Clk);
            cyc++;
        end

        // Model-checked directed sequences
        lat_max = 1;
        step(1, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 0);   // ready low: address held
        for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 32'h0, 1);   // stall: head held, req drops
        for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 1);
        step(0, 0, 1, 32'h200, 1);                             // back-to-back redirects
        step(0, 0, 1, 32'h300, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 1);
        step(0, 0, 1, 32'hFFFF_FFFC, 1);                       // PC wrap
        for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 1);
        lat_max = 3;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 1);
        step(0, 1, 1, 32'h100, 1);                             // redirect while stalled
        for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom;
            tg  = {rnd[31:2], 2'b00};
            if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF8;
            lat_max = int'($urandom_range(1, 4));
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 15) == 0,
                 tg,
                 $urandom_range(0, 9) < 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
